generator_sequencer: RTL and testbench
======================================

// Module: generator_sequencer
// PURPOSE
//  Sequences the 24-bit test-signal generator for the adaptive-filter chain.
//  Issues one generator advance strobe per programmable sample period.
//  Captures the generator output after its fixed latency.
//  Delivers each sample downstream over a valid/ready handshake; flags overruns when the consumer stalls.
// PARAMETERS
//  DATA_W   24      sample width (generator data_out width)
//  DIV_W    20      width of sample-period divider
//  GEN_LAT  2       clocks from gen_en to valid gen_data
//  CNT_W    32      width of delivered-sample counter
// PORTS
//  clk           in   1       system clock; single clock domain
//  reset         in   1       synchronous, active-high reset
//  start         in   1       1-cycle pulse: latch div_value, begin sampling
//  stop          in   1       1-cycle pulse: stop issuing new samples
//  div_value     in   DIV_W   sample period in clk cycles, sampled on start
//  gen_en        out  1       1-cycle advance strobe to generator
//  gen_data      in   DATA_W  generator output
//  sample_data   out  DATA_W  captured sample; stable while sample_valid=1
//  sample_valid  out  1       sample available downstream
//  sample_ready  in   1       downstream accepts when valid&ready
//  running       out  1       1 in RUN state
//  overrun       out  1       sticky: a tick was dropped because the buffer was busy
//  sample_cnt    out  CNT_W   number of completed handshakes; wraps
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; state=IDLE; period/latency counters cleared.
//   - Reset mid-operation aborts any in-flight capture and discards the pending sample.
//  Divider:
//   - div_eff = max(div_value, GEN_LAT+2), latched when start is accepted.
//   - Period counter runs 0..div_eff-1 in RUN only.
//   - tick when counter==div_eff-1; the counter then wraps to 0.
//   - The first tick occurs div_eff cycles after the start edge.
//  Tick handling:
//   - Buffer is free when no capture is in flight and sample_valid=0.
//   - On tick with buffer free: gen_en=1 for exactly that cycle; latency counter loads GEN_LAT.
//   - gen_data is captured at the end of cycle T+GEN_LAT; sample_valid=1 from T+GEN_LAT+1.
//   - On tick with buffer busy: no gen_en, overrun<=1, sample_data unchanged.
//  Handshake:
//   - sample_valid and sample_data hold until valid&ready; sample_valid=0 the next cycle.
//   - sample_cnt increments on each valid&ready.
//   - ready may be asserted before valid; no combinational path from ready to any output.
//  FSM:
//   - IDLE  --start-->  RUN. Latch div_eff, clear overrun, sample_cnt, period counter.
//   - RUN   --stop-->   DRAIN if the buffer is busy, else IDLE. A tick in the stop cycle is ignored.
//   - DRAIN --buffer free-->  IDLE. The in-flight capture completes; the pending sample is delivered.
//   - start in RUN or DRAIN is ignored.
//   - start and stop in the same cycle: stop wins (IDLE stays IDLE).
//  Flags:
//   - running=1 only in RUN.
//   - overrun is cleared only by reset or an accepted start.
// STRUCTURE
//  - Shared defs include afc_defs.vh: AFC_DATA_W=24, FSM state encodings (IDLE=0, RUN=1, DRAIN=2).
//  - One sub-module: sample_tick_div (DIV_W counter, enable, clear, load; 1-cycle tick output).
//  - Capture register, latency counter, FSM and sample counter live in the top module.
// TESTING
//  1. reset=1 for 10 cycles, then 0 -> all outputs 0, gen_en never asserted.
//  2. div_value=10, start, ready=1 -> gen_en every 10 cycles; valid exactly GEN_LAT+1 cycles after each gen_en; sample_data equals the generator value.
//  3. div_value=10, ready held 0 for 35 cycles -> first sample held; overrun=1 after 2nd tick; no gen_en while busy; 1 sample delivered on release.
//  4. div_value=1 -> clamped to 4: gen_en period 4 cycles, no overrun with ready=1.
//  5. stop 1 cycle after gen_en -> state DRAIN, running=0, sample delivered, then IDLE; no further gen_en; sample_cnt +1.
//  6. reset while sample_valid=1 mid-stall -> next cycle valid=0, overrun=0, sample_cnt=0, IDLE; start+stop same cycle -> stays IDLE.

Source files
------------

// File: rtl/generator_sequencer_pkg.sv
// Shared definitions for the test-signal generator sequencer: default widths,
// the generator latency, FSM state encodings and the minimum sample period.
package generator_sequencer_pkg;

    localparam int AFC_DATA_W  = 24;
    localparam int AFC_DIV_W   = 20;
    localparam int AFC_GEN_LAT = 2;
    localparam int AFC_CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // The shortest period that lets one capture finish before the next tick.
    function automatic int min_div(input int gen_lat);
        return gen_lat + 2;
    endfunction

endpackage

// File: rtl/generator_sequencer_tick_div.sv
// Programmable sample-period divider: counts 0..div-1 while enabled and
// flags the last count of each period with a one-cycle tick.
module sample_tick_div #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             at_end;

    assign at_end = (cnt_q == div_q - DIV_W'(1));
    assign tick   = en && at_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            if (load) begin
                div_q <= load_val;
            end
            if (clr) begin
                cnt_q <= '0;
            end else if (en) begin
                cnt_q <= at_end ? '0 : cnt_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/generator_sequencer.sv
// Paces the test-signal generator, captures each sample after the generator
// latency and hands it downstream over valid/ready, flagging dropped ticks.
module generator_sequencer
    import generator_sequencer_pkg::*;
#(
    parameter int DATA_W  = AFC_DATA_W,
    parameter int DIV_W   = AFC_DIV_W,
    parameter int GEN_LAT = AFC_GEN_LAT,
    parameter int CNT_W   = AFC_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DIV_W-1:0]  div_value,
    output logic              gen_en,
    input  logic [DATA_W-1:0] gen_data,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              running,
    output logic              overrun,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam int               LAT_W   = $clog2(GEN_LAT + 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(min_div(GEN_LAT));

    seq_state_e        state_q;
    logic [LAT_W-1:0]  lat_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              overrun_q;
    logic [CNT_W-1:0]  cnt_q;

    logic             tick;
    logic             run_en;
    logic             buf_free;
    logic             start_acc;
    logic             tick_acc;
    logic             handshake;
    logic [DIV_W-1:0] div_eff;

    assign div_eff   = (div_value < DIV_MIN) ? DIV_MIN : div_value;
    assign run_en    = (state_q == ST_RUN);
    assign buf_free  = (lat_q == '0) && !valid_q;
    // stop beats start, and a tick landing on the stop cycle is dropped silently.
    assign start_acc = (state_q == ST_IDLE) && start && !stop;
    assign tick_acc  = run_en && tick && !stop;
    assign handshake = valid_q && sample_ready;
    assign gen_en    = tick_acc && buf_free;

    sample_tick_div #(
        .DIV_W(DIV_W)
    ) u_tick_div (
        .clk      (clk),
        .reset    (reset),
        .en       (run_en),
        .clr      (start_acc),
        .load     (start_acc),
        .load_val (div_eff),
        .tick     (tick)
    );

    // NOTE: all state uses <= so every branch sees the pre-edge values; the
    // capture register is reset too, so no stale sample survives a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        state_q   <= ST_RUN;
                        overrun_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= buf_free ? ST_IDLE : ST_DRAIN;
                    end else if (tick && !buf_free) begin
                        overrun_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (buf_free) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (gen_en) begin
                lat_q <= LAT_W'(GEN_LAT);
            end else if (lat_q != '0) begin
                lat_q <= lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    data_q  <= gen_data;
                    valid_q <= 1'b1;
                end
            end

            if (handshake) begin
                valid_q <= 1'b0;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign running      = run_en;
    assign overrun      = overrun_q;
    assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_generator_sequencer.sv
// Directed bench for generator_sequencer: a stub generator with a two-clock
// output pipeline feeds the DUT and each step is checked against hand values.
module tb_generator_sequencer;
    import generator_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] div_value = '0;
    logic        gen_en;
    logic [23:0] gen_data;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        running;
    logic        overrun;
    logic [31:0] sample_cnt;

    int n_checks = 0;
    int n_errors = 0;

    generator_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .div_value    (div_value),
        .gen_en       (gen_en),
        .gen_data     (gen_data),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .running      (running),
        .overrun      (overrun),
        .sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;

    // Generator stub: value n appears on gen_data two clocks after the n-th gen_en.
    function automatic logic [23:0] gen_fn(input int n);
        return 24'hA50000 ^ (24'(n) * 24'h010F03);
    endfunction

    int          gen_cnt = 0;
    logic [23:0] g_q = '0;
    logic [23:0] p_q = '0;
    always @(posedge clk) begin
        if (gen_en) begin
            gen_cnt <= gen_cnt + 1;
            g_q     <= gen_fn(gen_cnt + 1);
        end
        p_q <= g_q;
    end
    assign gen_data = p_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gen(output int n);
        n = 0;
        while (gen_en !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    int          n;
    int          g;
    logic [23:0] exp_held;

    initial begin
        // 1: reset held for 10 cycles
        tick();
        check("rst_valid", sample_valid, 0);
        check("rst_running", running, 0);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        check("idle_gen_en", gen_en, 0);
        check("idle_valid", sample_valid, 0);
        check("idle_data", sample_data, 0);
        check("idle_running", running, 0);
        check("idle_overrun", overrun, 0);
        check("idle_cnt", sample_cnt, 0);
        check("idle_gen_cnt", gen_cnt, 0);

        // 2: period 10, consumer always ready
        div_value    = 20'd10;
        sample_ready = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("t2_running", running, 1);
        for (int i = 0; i < 3; i++) begin
            wait_gen(n);
            check("t2_period", n, (i == 0) ? 9 : 6);
            tick();
            check("t2_lat1", sample_valid, 0);
            tick();
            check("t2_lat2", sample_valid, 0);
            tick();
            check("t2_valid", sample_valid, 1);
            check("t2_data", sample_data, gen_fn(gen_cnt));
            tick();
            check("t2_drop", sample_valid, 0);
            check("t2_cnt", sample_cnt, i + 1);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t2_stop_running", running, 0);
        check("t2_stop_state", dut.state_q, ST_IDLE);

        // 3: consumer stalls for 35 cycles
        sample_ready = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        check("t3_overrun_clr", overrun, 0);
        check("t3_cnt_clr", sample_cnt, 0);
        wait_gen(n);
        check("t3_first", n, 9);
        repeat (3) tick();
        exp_held = gen_fn(gen_cnt);
        check("t3_valid", sample_valid, 1);
        check("t3_data", sample_data, exp_held);
        g = gen_cnt;
        repeat (32) tick();
        check("t3_hold_valid", sample_valid, 1);
        check("t3_hold_data", sample_data, exp_held);
        check("t3_overrun", overrun, 1);
        check("t3_no_gen", gen_cnt, g);
        sample_ready = 1'b1;
        tick();
        check("t3_release", sample_valid, 0);
        check("t3_cnt", sample_cnt, 1);
        wait_gen(n);
        check("t3_resume", n, 4);

        // 5: stop one cycle after gen_en drains the in-flight sample
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_drain", dut.state_q, ST_DRAIN);
        check("t5_running", running, 0);
        tick();
        check("t5_valid", sample_valid, 1);
        check("t5_data", sample_data, gen_fn(gen_cnt));
        tick();
        check("t5_cnt", sample_cnt, 2);
        check("t5_still_drain", dut.state_q, ST_DRAIN);
        tick();
        check("t5_idle", dut.state_q, ST_IDLE);
        g = gen_cnt;
        repeat (20) tick();
        check("t5_no_gen", gen_cnt, g);

        // 4: div_value below the minimum clamps to 4
        div_value = 20'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_gen(n);
            check("t4_period", n, (i == 0) ? 3 : 1);
            repeat (3) tick();
            check("t4_valid", sample_valid, 1);
            check("t4_data", sample_data, gen_fn(gen_cnt));
        end
        check("t4_overrun", overrun, 0);
        check("t4_cnt", sample_cnt, 3);

        // 6: reset during a stall, then simultaneous start and stop
        sample_ready = 1'b0;
        repeat (6) tick();
        check("t6_stall_valid", sample_valid, 1);
        check("t6_stall_overrun", overrun, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", sample_valid, 0);
        check("t6_overrun", overrun, 0);
        check("t6_cnt", sample_cnt, 0);
        check("t6_data", sample_data, 0);
        check("t6_state", dut.state_q, ST_IDLE);
        div_value = 20'd10;
        start     = 1'b1;
        stop      = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t6_ss_running", running, 0);
        check("t6_ss_state", dut.state_q, ST_IDLE);
        g = gen_cnt;
        repeat (15) tick();
        check("t6_no_gen", gen_cnt, g);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
